// File: rtl/trdb_pkg.sv
// Shared types for the trace qualify pipeline: instruction attributes, per-stage
// qualifier flag bundles, stage register layout and the sequencing states.
package trdb_pkg;

    localparam int BMAP_LEN_DEFAULT   = 31;
    localparam int RESYNC_MAX_DEFAULT = 16;

    typedef struct packed {
        logic       retired;
        logic       exception;
        logic       updiscon;
        logic       branch;
        logic       taken;
        logic       ctx_change;
        logic [1:0] priv;
        logic [1:0] opmode;
    } inst_t;

    typedef struct packed {
        logic exception;
        logic updiscon;
        logic final_qualified;
    } lc_flags_t;

    typedef struct packed {
        logic qualified;
        logic exception;
        logic retired;
        logic first_qualified;
        logic privchange;
        logic max_resync;
        logic bmap_empty;
        logic bmap_full;
        logic enc_enabled;
        logic enc_disabled;
        logic opmode_change;
    } tc_flags_t;

    typedef struct packed {
        logic exception;
        logic privchange;
        logic ctx_change;
        logic bmap_empty;
        logic qualified;
        logic retired;
    } nc_flags_t;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} qpipe_state_e;

    typedef struct packed {
        inst_t inst;
        logic  qualified;
        logic  enc_en;
        logic  enc_dis;
        logic  loaded;
    } stage_t;

endpackage

// File: rtl/trdb_branch_map.sv
// Branch history map: one bit per branch entering tc (1 = not taken), cleared
// when a packet is emitted; branches arriving while full are dropped and flagged.
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int  BMAP_LEN = BMAP_LEN_DEFAULT,
    localparam int CNT_W    = $clog2(BMAP_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                append,
    input  logic                not_taken,
    output logic [BMAP_LEN-1:0] map,
    output logic [CNT_W-1:0]    cnt,
    output logic [CNT_W-1:0]    cnt_next,
    output logic                empty,
    output logic                full,
    output logic                overflow
);

    logic [BMAP_LEN-1:0] base_map;
    logic [BMAP_LEN-1:0] map_next;
    logic [CNT_W-1:0]    base_cnt;
    logic                drop;

    // Clear happens before the append so a same-edge branch lands at bit 0.
    always_comb begin
        base_map = clear ? '0 : map;
        base_cnt = clear ? '0 : cnt;
        map_next = base_map;
        cnt_next = base_cnt;
        drop     = 1'b0;
        if (append) begin
            if (base_cnt == CNT_W'(BMAP_LEN)) begin
                drop = 1'b1;
            end else begin
                map_next = base_map | (BMAP_LEN'(not_taken) << base_cnt);
                cnt_next = base_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            map <= map_next;
            cnt <= cnt_next;
            if (drop) overflow <= 1'b1;
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(BMAP_LEN));

endmodule

// File: rtl/trdb_qualify_pipe.sv
// Last/this/next-cycle pipeline of retired-instruction attributes with enable
// sequencing (fill, run, drain with bubbles), qualifier flags and resync counting.
module trdb_qualify_pipe
    import trdb_pkg::*;
#(
    parameter int  BMAP_LEN   = BMAP_LEN_DEFAULT,
    parameter int  RESYNC_MAX = RESYNC_MAX_DEFAULT,
    localparam int CNT_W      = $clog2(BMAP_LEN + 1),
    localparam int RS_W       = $clog2(RESYNC_MAX + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                step_i,
    input  inst_t               inst_i,
    input  logic                qualified_i,
    input  logic                trace_enable_i,
    input  logic                packet_emitted_i,
    input  logic                resync_rst_i,
    output logic                valid_o,
    output lc_flags_t           lc_o,
    output tc_flags_t           tc_o,
    output nc_flags_t           nc_o,
    output logic [BMAP_LEN-1:0] branch_map_o,
    output logic [CNT_W-1:0]    branch_cnt_o,
    output logic                busy_o,
    output logic                overflow_o
);

    qpipe_state_e     state;
    stage_t           lc, tc, nc;
    stage_t           sample, bubble_stage;
    logic [1:0]       drain_cnt;
    logic             enable_q, en_pend;
    logic [RS_W-1:0]  resync_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             enable_rise, bubble, shift, bmap_empty, bmap_full;

    assign enable_rise = trace_enable_i & ~enable_q;
    assign bubble      = (state == DRAIN) && (drain_cnt != 2'd2);
    assign shift       = bubble || (((state == FILL) || (state == RUN)) && step_i && trace_enable_i);

    always_comb begin
        sample           = '0;
        sample.inst      = inst_i;
        sample.qualified = qualified_i;
        sample.enc_en    = en_pend;
        sample.loaded    = 1'b1;
        bubble_stage             = '0;
        bubble_stage.inst.priv   = nc.inst.priv;
        bubble_stage.inst.opmode = nc.inst.opmode;
        bubble_stage.loaded      = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lc         <= '0;
            tc         <= '0;
            nc         <= '0;
            drain_cnt  <= '0;
            enable_q   <= 1'b0;
            en_pend    <= 1'b0;
            resync_cnt <= '0;
        end else begin
            enable_q <= trace_enable_i;
            if (shift) begin
                lc <= tc;
                tc <= nc;
                nc <= bubble ? bubble_stage : sample;
                if (!bubble) en_pend <= 1'b0;
            end
            case (state)
                IDLE: if (enable_rise) begin
                    state   <= FILL;
                    en_pend <= 1'b1;
                end
                FILL: if (!trace_enable_i) begin
                    state   <= IDLE;
                    en_pend <= 1'b0;
                    lc      <= '0;
                    tc      <= '0;
                    nc      <= '0;
                end else if (tc.loaded && nc.loaded) begin
                    state <= RUN;
                end
                RUN: if (!trace_enable_i) begin
                    state      <= DRAIN;
                    drain_cnt  <= '0;
                    nc.enc_dis <= 1'b1;
                end
                DRAIN: if (drain_cnt == 2'd2) begin
                    state <= IDLE;
                    lc    <= '0;
                    tc    <= '0;
                    nc    <= '0;
                end else begin
                    drain_cnt <= drain_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
            if (resync_rst_i || ((state == IDLE) && enable_rise))
                resync_cnt <= '0;
            else if (packet_emitted_i && (resync_cnt != RS_W'(RESYNC_MAX)))
                resync_cnt <= resync_cnt + RS_W'(1);
        end
    end

    trdb_branch_map #(.BMAP_LEN(BMAP_LEN)) u_branch_map (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (packet_emitted_i),
        .append    (shift && nc.inst.branch),
        .not_taken (!nc.inst.taken),
        .map       (branch_map_o),
        .cnt       (branch_cnt_o),
        .cnt_next  (cnt_next),
        .empty     (bmap_empty),
        .full      (bmap_full),
        .overflow  (overflow_o)
    );

    // Flags of an empty stage read as zero, so an idle pipe presents all-zero outputs.
    always_comb begin
        lc_o = '0;
        tc_o = '0;
        nc_o = '0;
        if (lc.loaded) begin
            lc_o.exception       = lc.inst.exception;
            lc_o.updiscon        = lc.inst.updiscon;
            lc_o.final_qualified = lc.qualified & ~tc.qualified;
        end
        if (tc.loaded) begin
            tc_o.qualified       = tc.qualified;
            tc_o.exception       = tc.inst.exception;
            tc_o.retired         = tc.inst.retired;
            tc_o.first_qualified = tc.qualified & ~(lc.loaded & lc.qualified);
            tc_o.privchange      = lc.loaded & (tc.inst.priv != lc.inst.priv);
            tc_o.max_resync      = (resync_cnt == RS_W'(RESYNC_MAX));
            tc_o.bmap_empty      = bmap_empty;
            tc_o.bmap_full       = bmap_full;
            tc_o.enc_enabled     = tc.enc_en;
            tc_o.enc_disabled    = tc.enc_dis;
            tc_o.opmode_change   = lc.loaded & (tc.inst.opmode != lc.inst.opmode);
        end
        if (nc.loaded) begin
            nc_o.exception  = nc.inst.exception;
            nc_o.privchange = (nc.inst.priv != tc.inst.priv);
            nc_o.ctx_change = nc.inst.ctx_change;
            nc_o.bmap_empty = (cnt_next == '0);
            nc_o.qualified  = nc.qualified;
            nc_o.retired    = nc.inst.retired;
        end
    end

    assign valid_o = tc.loaded & nc.loaded;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_trdb_qualify_pipe.sv
// Bench for trdb_qualify_pipe: directed sequences, a branch-map vector table and
// randomized run-mode traffic checked against a history-queue reference model.
module tb_trdb_qualify_pipe;
    import trdb_pkg::*;

    localparam int BL = 31;
    localparam int RM = 4;

    logic      clk_i = 1'b0;
    logic      rst_i, step_i, qualified_i, trace_enable_i, packet_emitted_i, resync_rst_i;
    inst_t     inst_i;
    logic      valid_o, busy_o, overflow_o;
    lc_flags_t lc_o;
    tc_flags_t tc_o;
    nc_flags_t nc_o;
    logic [BL-1:0] branch_map_o;
    logic [4:0]    branch_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    trdb_qualify_pipe #(.BMAP_LEN(BL), .RESYNC_MAX(RM)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .step_i           (step_i),
        .inst_i           (inst_i),
        .qualified_i      (qualified_i),
        .trace_enable_i   (trace_enable_i),
        .packet_emitted_i (packet_emitted_i),
        .resync_rst_i     (resync_rst_i),
        .valid_o          (valid_o),
        .lc_o             (lc_o),
        .tc_o             (tc_o),
        .nc_o             (nc_o),
        .branch_map_o     (branch_map_o),
        .branch_cnt_o     (branch_cnt_o),
        .busy_o           (busy_o),
        .overflow_o       (overflow_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic st, input inst_t ins, input logic q,
                          input logic emit, input logic rr);
        @(negedge clk_i);
        trace_enable_i   = en;
        step_i           = st;
        inst_i           = ins;
        qualified_i      = q;
        packet_emitted_i = emit;
        resync_rst_i     = rr;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    function automatic inst_t mk(input logic br, input logic tk, input logic [1:0] pv);
        inst_t r;
        r         = '0;
        r.retired = 1'b1;
        r.branch  = br;
        r.taken   = tk;
        r.priv    = pv;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(valid_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_ovf"}, 64'(overflow_o), 64'(0));
        chk({tag, "_cnt"}, 64'(branch_cnt_o), 64'(0));
        chk({tag, "_map"}, 64'(branch_map_o), 64'(0));
        chk({tag, "_lc"}, 64'(lc_o), 64'(0));
        chk({tag, "_tc"}, 64'(tc_o), 64'(0));
        chk({tag, "_nc"}, 64'(nc_o), 64'(0));
    endtask

    typedef struct {
        logic       br;
        logic       tk;
        logic       emit;
        logic [4:0] cnt;
        logic [3:0] map;
    } row_t;

    typedef struct {
        inst_t inst;
        logic  q;
        logic  en;
    } ent_t;

    initial begin
        row_t          rows[7];
        ent_t          hist[$];
        bit            bq[$];
        int            rs;
        bit            ovf, first;
        logic [BL-1:0] em;
        tc_flags_t     et;
        lc_flags_t     el;
        nc_flags_t     en_f;
        ent_t          t, l, c, ne;
        logic          st, q, emit, rr;
        inst_t         ri;
        int            n, s;
        logic [1:0]    tc_priv;

        rows[0] = '{1'b0, 1'b0, 1'b1, 5'd0, 4'h0};
        rows[1] = '{1'b1, 1'b0, 1'b0, 5'd0, 4'h0};
        rows[2] = '{1'b1, 1'b1, 1'b0, 5'd1, 4'h1};
        rows[3] = '{1'b1, 1'b0, 1'b0, 5'd2, 4'h1};
        rows[4] = '{1'b0, 1'b0, 1'b0, 5'd3, 4'h5};
        rows[5] = '{1'b1, 1'b0, 1'b0, 5'd3, 4'h5};
        rows[6] = '{1'b0, 1'b0, 1'b1, 5'd1, 4'h1};

        rst_i = 1'b1; trace_enable_i = 0; step_i = 0; inst_i = '0;
        qualified_i = 0; packet_emitted_i = 0; resync_rst_i = 0;
        #12;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Enable then three qualified steps.
        set_in(1, 0, '0, 0, 0, 0);
        after_edge();
        chk("fill_busy", 64'(busy_o), 64'(1));
        set_in(1, 1, mk(0, 0, 2'd3), 1, 0, 0);
        after_edge();
        chk("fill_valid1", 64'(valid_o), 64'(0));
        set_in(1, 1, mk(0, 0, 2'd3), 1, 0, 0);
        after_edge();
        chk("fill_valid2", 64'(valid_o), 64'(1));
        chk("fill_firstq", 64'(tc_o.first_qualified), 64'(1));
        chk("fill_encen", 64'(tc_o.enc_enabled), 64'(1));
        set_in(1, 1, mk(0, 0, 2'd3), 1, 0, 0);
        after_edge();
        chk("run_encen_off", 64'(tc_o.enc_enabled), 64'(0));
        chk("run_firstq_off", 64'(tc_o.first_qualified), 64'(0));

        // Branch map vector table.
        for (int i = 0; i < 7; i++) begin
            set_in(1, 1, mk(rows[i].br, rows[i].tk, 2'd3), 1, rows[i].emit, 0);
            after_edge();
            chk($sformatf("tbl%0d_cnt", i), 64'(branch_cnt_o), 64'(rows[i].cnt));
            chk($sformatf("tbl%0d_map", i), 64'(branch_map_o), 64'({27'd0, rows[i].map}));
        end

        // Resync counter saturation and clear-over-increment.
        set_in(1, 0, '0, 0, 0, 1);
        after_edge();
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 0, '0, 0, 1, 0);
            after_edge();
            chk($sformatf("rs_a%0d", i), 64'(tc_o.max_resync), 64'(i >= RM));
        end
        set_in(1, 0, '0, 0, 1, 1);
        after_edge();
        chk("rs_clear", 64'(tc_o.max_resync), 64'(0));
        for (int i = 1; i <= RM; i++) begin
            set_in(1, 0, '0, 0, 1, 0);
            after_edge();
            chk($sformatf("rs_b%0d", i), 64'(tc_o.max_resync), 64'(i == RM));
        end
        set_in(1, 0, '0, 0, 0, 0);

        // Fill the map with 31 branches, then one more that must be dropped.
        em = '0;
        for (int j = 0; j < BL; j++) em[j] = ((j % 3) != 0);
        for (int i = 0; i < 32; i++) begin
            set_in(1, 1, mk(1, (i % 3) == 0, 2'd3), 1, 0, 0);
            after_edge();
        end
        chk("full_cnt", 64'(branch_cnt_o), 64'(31));
        chk("full_flag", 64'(tc_o.bmap_full), 64'(1));
        chk("full_ovf0", 64'(overflow_o), 64'(0));
        chk("full_map", 64'(branch_map_o), 64'(em));
        set_in(1, 1, mk(0, 0, 2'd3), 1, 0, 0);
        after_edge();
        chk("ovf_set", 64'(overflow_o), 64'(1));
        chk("ovf_cnt", 64'(branch_cnt_o), 64'(31));
        chk("ovf_map", 64'(branch_map_o), 64'(em));

        // Asynchronous reset mid-RUN with a full map.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized run traffic against the reference model.
        set_in(1, 0, '0, 0, 0, 0);
        after_edge();
        rs = 0; ovf = 0; first = 1;
        for (int k = 0; k < 400; k++) begin
            st   = ($urandom_range(0, 9) < 7);
            ri   = inst_t'(10'($urandom));
            q    = 1'($urandom);
            emit = ($urandom_range(0, 6) == 0);
            rr   = ($urandom_range(0, 19) == 0);
            set_in(1, st, ri, q, emit, rr);

            n  = hist.size();
            el = '0; et = '0; en_f = '0;
            tc_priv = 2'd0;
            if (n >= 2) begin
                t = hist[n-2];
                tc_priv = t.inst.priv;
                et.qualified     = t.q;
                et.exception     = t.inst.exception;
                et.retired       = t.inst.retired;
                et.max_resync    = (rs == RM);
                et.bmap_empty    = (bq.size() == 0);
                et.bmap_full     = (bq.size() == BL);
                et.enc_enabled   = t.en;
                et.first_qualified = t.q;
                if (n >= 3) begin
                    l = hist[n-3];
                    et.first_qualified = t.q && !l.q;
                    et.privchange      = (t.inst.priv != l.inst.priv);
                    et.opmode_change   = (t.inst.opmode != l.inst.opmode);
                    el.exception       = l.inst.exception;
                    el.updiscon        = l.inst.updiscon;
                    el.final_qualified = l.q && !t.q;
                end
            end
            if (n >= 1) begin
                c = hist[n-1];
                s = emit ? 0 : bq.size();
                if (st && c.inst.branch && s < BL) s++;
                en_f.exception  = c.inst.exception;
                en_f.privchange = (c.inst.priv != tc_priv);
                en_f.ctx_change = c.inst.ctx_change;
                en_f.bmap_empty = (s == 0);
                en_f.qualified  = c.q;
                en_f.retired    = c.inst.retired;
            end
            em = '0;
            for (int j = 0; j < bq.size(); j++) em[j] = bq[j];
            chk("rnd_valid", 64'(valid_o), 64'(n >= 2));
            chk("rnd_busy", 64'(busy_o), 64'(1));
            chk("rnd_lc", 64'(lc_o), 64'(el));
            chk("rnd_tc", 64'(tc_o), 64'(et));
            chk("rnd_nc", 64'(nc_o), 64'(en_f));
            chk("rnd_cnt", 64'(branch_cnt_o), 64'(bq.size()));
            chk("rnd_map", 64'(branch_map_o), 64'(em));
            chk("rnd_ovf", 64'(overflow_o), 64'(ovf));

            @(posedge clk_i);
            if (emit) bq.delete();
            if (st && n >= 1 && hist[n-1].inst.branch) begin
                if (bq.size() < BL) bq.push_back(!hist[n-1].inst.taken);
                else ovf = 1;
            end
            if (rr) rs = 0;
            else if (emit && rs < RM) rs++;
            if (st) begin
                ne.inst = ri; ne.q = q; ne.en = first;
                first = 0;
                hist.push_back(ne);
                if (hist.size() > 3) void'(hist.pop_front());
            end
        end

        // Disable from RUN: two bubbles, then idle; step and re-enable ignored.
        set_in(1, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        set_in(0, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        chk("drain_busy0", 64'(busy_o), 64'(1));
        set_in(0, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        chk("drain_encdis", 64'(tc_o.enc_disabled), 64'(1));
        chk("drain_tcq", 64'(tc_o.qualified), 64'(1));
        chk("drain_nc_ret", 64'(nc_o.retired), 64'(0));
        chk("drain_nc_q", 64'(nc_o.qualified), 64'(0));
        chk("drain_valid", 64'(valid_o), 64'(1));
        set_in(1, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        chk("drain_finalq", 64'(lc_o.final_qualified), 64'(1));
        chk("drain_tcq2", 64'(tc_o.qualified), 64'(0));
        chk("drain_busy1", 64'(busy_o), 64'(1));
        set_in(1, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        chk("drain_idle", 64'(busy_o), 64'(0));
        chk("drain_valid0", 64'(valid_o), 64'(0));
        set_in(1, 1, mk(0, 0, 2'd1), 1, 0, 0);
        after_edge();
        chk("drain_stay_idle", 64'(busy_o), 64'(0));

        // Enable falling during FILL flushes straight to IDLE.
        set_in(0, 0, '0, 0, 0, 0);
        after_edge();
        set_in(1, 0, '0, 0, 0, 0);
        after_edge();
        chk("flush_fill", 64'(busy_o), 64'(1));
        set_in(1, 1, mk(0, 0, 2'd2), 1, 0, 0);
        after_edge();
        set_in(0, 1, mk(0, 0, 2'd2), 1, 0, 0);
        after_edge();
        chk("flush_busy", 64'(busy_o), 64'(0));
        chk("flush_valid", 64'(valid_o), 64'(0));
        chk("flush_nc", 64'(nc_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
